// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder: STEP bits per clock through a registered carry, start/busy/done handshake.
// Latency N=WIDTH/STEP cycles from accept to done; start is ignored while busy, with no queueing.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("serial_adder: STEP must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] sreg;
  logic             carry;

  logic [STEP-1:0]  slice;
  logic             slice_c;
  logic             msb_cin;
  logic [WIDTH-1:0] sreg_nxt;
  logic             last;

  always_comb begin
    {slice_c, slice} = {1'b0, areg[STEP-1:0]} + {1'b0, breg[STEP-1:0]} + {{STEP{1'b0}}, carry};
    // Carry into the slice MSB recovered from its sum bit; only meaningful on the last slice.
    msb_cin  = areg[STEP-1] ^ breg[STEP-1] ^ slice[STEP-1];
    sreg_nxt = (sreg >> STEP) | (WIDTH'(slice) << (WIDTH - STEP));
    last     = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          areg  <= areg >> STEP;
          breg  <= breg >> STEP;
          sreg  <= sreg_nxt;
          carry <= slice_c;
          if (last) begin
            // Published result only changes here; it holds through RUN/IDLE otherwise.
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= sreg_nxt;
            cout  <= slice_c;
            ovf   <= msb_cin ^ slice_c;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (STEP=1, 4, 8 at WIDTH=8), vector table, corner sequences, random ops.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [3];
  logic       start [3];
  logic [7:0] a     [3];
  logic [7:0] b     [3];
  logic       cin   [3];
  logic       busy  [3];
  logic       done  [3];
  logic [7:0] sum   [3];
  logic       cout  [3];
  logic       ovf   [3];

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .a(a[0]), .b(b[0]), .cin(cin[0]),
    .busy(busy[0]), .done(done[0]), .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]));

  serial_adder #(.WIDTH(8), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .a(a[1]), .b(b[1]), .cin(cin[1]),
    .busy(busy[1]), .done(done[1]), .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]));

  serial_adder #(.WIDTH(8), .STEP(8)) u_s8 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .a(a[2]), .b(b[2]), .cin(cin[2]),
    .busy(busy[2]), .done(done[2]), .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum for sum/cout, signed range test for overflow.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
    int u;
    int sv;
    logic [9:0] r;
    u  = int'(x) + int'(y) + int'(c);
    sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    r[7:0] = u[7:0];
    r[8]   = (u > 255);
    r[9]   = (sv > 127) || (sv < -128);
    return r;
  endfunction

  function automatic int nsteps(input int d);
    case (d)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Called at a negedge with the DUT not running; returns at the negedge where done is seen.
  task automatic run_add(input int d, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         output logic [7:0] s, output logic co, output logic ov,
                         output int lat, output int bc, output logic [7:0] mid);
    start[d] = 1'b1; a[d] = av; b[d] = bv; cin[d] = cv;
    @(negedge clk);
    start[d] = 1'b0; a[d] = ~av; b[d] = ~bv; cin[d] = ~cv;
    lat = -1;
    bc  = 0;
    mid = sum[d];
    for (int c = 1; c <= 40; c++) begin
      if (done[d]) begin
        lat = c - 1;
        break;
      end
      if (busy[d]) bc++;
      @(negedge clk);
    end
    s  = sum[d];
    co = cout[d];
    ov = ovf[d];
    chk("done_seen", int'(lat >= 0), 1);
    chk("busy_at_done", int'(busy[d]), 0);
  endtask

  initial begin
    logic [7:0] s, mid;
    logic       co, ov;
    int         lat, bc, dn, bz, ops, g;
    logic [7:0] prev [3];
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rc;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 8'hA5, 1'b1, 8'hE2, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h40, 8'h3F, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'hC0, 8'hBF, 1'b0, 8'h7F, 1'b1, 1'b1};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; a[d] = 8'h00; b[d] = 8'h00; cin[d] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", int'(busy[d]), 0);
      chk("rst_done", int'(done[d]), 0);
      chk("rst_sum", int'(sum[d]), 0);
      chk("rst_cout", int'(cout[d]), 0);
      chk("rst_ovf", int'(ovf[d]), 0);
      rst[d] = 1'b0;
    end
    @(negedge clk);

    // Vector table on the bit-serial instance.
    for (int i = 0; i < 8; i++) begin
      run_add(0, tbl[i].a, tbl[i].b, tbl[i].c, s, co, ov, lat, bc, mid);
      chk("tbl_sum", int'(s), int'(tbl[i].s));
      chk("tbl_cout", int'(co), int'(tbl[i].co));
      chk("tbl_ovf", int'(ov), int'(tbl[i].ov));
      chk("tbl_lat", lat, 8);
      chk("tbl_busy_cycles", bc, 8);
      @(negedge clk);
      chk("tbl_done_pulse", int'(done[0]), 0);
      chk("tbl_sum_hold", int'(sum[0]), int'(tbl[i].s));
    end

    // Back-to-back: second start lands in the DONE cycle.
    run_add(0, 8'h3C, 8'hA5, 1'b1, s, co, ov, lat, bc, mid);
    chk("b2b_first_sum", int'(s), 8'hE2);
    run_add(0, 8'h01, 8'h01, 1'b0, s, co, ov, lat, bc, mid);
    chk("b2b_hold_during_run", int'(mid), 8'hE2);
    chk("b2b_lat", lat, 8);
    chk("b2b_sum", int'(s), 8'h02);
    @(negedge clk);

    // Start pulsed mid-run must be ignored.
    start[0] = 1'b1; a[0] = 8'h10; b[0] = 8'h20; cin[0] = 1'b0;
    @(negedge clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      start[0] = (c == 3);
      a[0] = 8'hFF; b[0] = 8'hFF;
      if (done[0]) begin
        lat = c - 1;
        break;
      end
      @(negedge clk);
    end
    start[0] = 1'b0;
    chk("ign_lat", lat, 8);
    chk("ign_sum", int'(sum[0]), 8'h30);
    dn = 0; bz = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dn += int'(done[0]);
      bz += int'(busy[0]);
    end
    chk("ign_no_extra_done", dn, 0);
    chk("ign_no_extra_busy", bz, 0);

    // Reset during RUN aborts the add.
    start[0] = 1'b1; a[0] = 8'h55; b[0] = 8'h22; cin[0] = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    chk("abort_sum", int'(sum[0]), 0);
    chk("abort_cout", int'(cout[0]), 0);
    @(negedge clk);
    rst[0] = 1'b0;
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      dn += int'(done[0]);
    end
    chk("abort_no_done", dn, 0);

    // Four bits per clock.
    run_add(1, 8'hF0, 8'h10, 1'b0, s, co, ov, lat, bc, mid);
    chk("s4_sum", int'(s), 8'h00);
    chk("s4_cout", int'(co), 1);
    chk("s4_ovf", int'(ov), 0);
    chk("s4_lat", lat, 2);
    chk("s4_busy_cycles", bc, 2);
    @(negedge clk);

    // Random operations against the arithmetic model on every instance.
    prev[0] = 8'h00;
    prev[1] = 8'h00;
    prev[2] = 8'h00;
    for (int d = 0; d < 3; d++) begin
      ops = (d == 1) ? 1000 : 250;
      for (int i = 0; i < ops; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        m  = model(ra, rb, rc);
        run_add(d, ra, rb, rc, s, co, ov, lat, bc, mid);
        chk("rnd_sum", int'(s), int'(m[7:0]));
        chk("rnd_cout", int'(co), int'(m[8]));
        chk("rnd_ovf", int'(ov), int'(m[9]));
        chk("rnd_lat", lat, nsteps(d));
        chk("rnd_hold", int'(mid), int'(prev[d]));
        prev[d] = m[7:0];
        g = $urandom_range(0, 2);
        if (g > 0) begin
          @(negedge clk);
          chk("rnd_done_pulse", int'(done[d]), 0);
          for (int k = 1; k < g; k++) @(negedge clk);
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
